// File: rtl/seq_hit_monitor_if.sv
// Bundles the detector pulse and clear inputs with the monitor's status outputs.
interface seq_hit_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             det;
    logic             clr;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] win_cnt;
    logic             alarm;
    logic             ovf;

    modport master (
        output det,
        output clr,
        input  total,
        input  win_cnt,
        input  alarm,
        input  ovf
    );

    modport slave (
        input  det,
        input  clr,
        output total,
        output win_cnt,
        output alarm,
        output ovf
    );
endinterface

// File: rtl/seq_hit_monitor.sv
// Counts sequence-detector hits and raises a sticky alarm when THRESH hits land in one window.
// Define SEQ_HIT_EDGE_EN to count only 0->1 transitions of det instead of every high cycle.
module seq_hit_monitor #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WINDOW = 16,
    parameter int unsigned THRESH = 2
) (
    input logic             clk,
    input logic             rst,
    seq_hit_monitor_if.slave bus
);
    localparam int unsigned TimerW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(WINDOW - 1);
    localparam logic [CNT_W:0] ThreshW = (CNT_W + 1)'(THRESH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StOpen  = 2'd1;
    localparam logic [1:0] StAlarm = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic              alarm_q, alarm_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W:0]    win_inc;
    logic              hit;

`ifdef SEQ_HIT_EDGE_EN
    logic det_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_prev_q <= 1'b0;
        end else begin
            det_prev_q <= bus.clr ? 1'b0 : bus.det;
        end
    end

    assign hit = bus.det & ~det_prev_q;
`else
    assign hit = bus.det;
`endif

    assign win_inc = {1'b0, win_q} + 1'b1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        win_d   = win_q;
        total_d = total_q;
        alarm_d = alarm_q;
        ovf_d   = ovf_q;
        if (bus.clr) begin
            state_d = StIdle;
            timer_d = '0;
            win_d   = '0;
            total_d = '0;
            alarm_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            if (hit) begin
                if (total_q == '1) begin
                    ovf_d = 1'b1;
                end else begin
                    total_d = total_q + 1'b1;
                end
            end
            case (state_q)
                StIdle: begin
                    if (hit) begin
                        win_d   = CNT_W'(1);
                        timer_d = TimerLoad;
                        if (THRESH == 1) begin
                            alarm_d = 1'b1;
                            state_d = StAlarm;
                        end else begin
                            state_d = StOpen;
                        end
                    end
                end
                StOpen: begin
                    // Reaching the threshold wins over window expiry in the same cycle.
                    if (hit && (win_inc >= ThreshW)) begin
                        win_d   = win_inc[CNT_W-1:0];
                        alarm_d = 1'b1;
                        state_d = StAlarm;
                    end else if (timer_q == '0) begin
                        if (hit) begin
                            win_d   = CNT_W'(1);
                            timer_d = TimerLoad;
                        end else begin
                            win_d   = '0;
                            state_d = StIdle;
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                        if (hit) begin
                            win_d = win_inc[CNT_W-1:0];
                        end
                    end
                end
                StAlarm: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            win_q   <= '0;
            total_q <= '0;
            alarm_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            win_q   <= win_d;
            total_q <= total_d;
            alarm_q <= alarm_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.total   = total_q;
    assign bus.win_cnt = win_q;
    assign bus.alarm   = alarm_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_seq_hit_monitor.sv
// Self-checking bench for seq_hit_monitor: vector tables through a scoreboard queue plus
// hand-written reset and saturation sequences.
module tb_seq_hit_monitor;
    typedef struct {
        string tag;
        logic  det;
        logic  clr;
        int    total;
        int    win;
        logic  alarm;
        logic  ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    vec_t exp_q[$];
    vec_t tbl[$];

    seq_hit_monitor_if #(.CNT_W(8)) bus_m ();
    seq_hit_monitor_if #(.CNT_W(4)) bus_s ();

    seq_hit_monitor #(.CNT_W(8), .WINDOW(16), .THRESH(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
    );

    seq_hit_monitor #(.CNT_W(4), .WINDOW(4), .THRESH(15)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string tag, logic d, logic c, int tot, int win, logic al,
                                logic ov);
        vec_t v;
        v.tag = tag; v.det = d; v.clr = c; v.total = tot; v.win = win; v.alarm = al; v.ovf = ov;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_main(vec_t e);
        check({e.tag, ".total"}, 32'(bus_m.total), 32'(e.total));
        check({e.tag, ".win_cnt"}, 32'(bus_m.win_cnt), 32'(e.win));
        check({e.tag, ".alarm"}, 32'(bus_m.alarm), 32'(e.alarm));
        check({e.tag, ".ovf"}, 32'(bus_m.ovf), 32'(e.ovf));
    endtask

    // Drive one cycle, queue its expectation, and compare just after the capturing edge.
    task automatic apply(vec_t v);
        vec_t e;
        @(negedge clk);
        bus_m.det = v.det;
        bus_m.clr = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = exp_q.pop_front();
            check_main(e);
        end
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        n_checks = 0;
        n_err = 0;
        rst = 1'b0;
        bus_m.det = 1'b0; bus_m.clr = 1'b0;
        bus_s.det = 1'b0; bus_s.clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_main(mk("reset", 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;

        // Mealy-style pulses two cycles apart, then clr with a coincident det.
        tbl.push_back(mk("mealy_p1", 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("mealy_gap1", 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk("mealy_p2", 1, 0, 2, 2, 1, 0));
        tbl.push_back(mk("alarm_hold", 0, 0, 2, 2, 1, 0));
        tbl.push_back(mk("alarm_frozen", 1, 0, 3, 2, 1, 0));
        tbl.push_back(mk("clr_with_det", 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk("after_clr", 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("idle_p1", 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("idle_gap", 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk("idle_p2", 1, 0, 2, 2, 1, 0));
        tbl.push_back(mk("clr2", 0, 1, 0, 0, 0, 0));
        run_tbl();

        // Single pulse: window closes exactly 16 edges after the opening hit.
        apply(mk("win_open", 1, 0, 1, 1, 0, 0));
        for (int i = 0; i < 20; i++) begin
            apply(mk($sformatf("win_tail%0d", i), 0, 0, 1, (i < 15) ? 1 : 0, 0, 0));
        end
        apply(mk("clr3", 0, 1, 0, 0, 0, 0));

        // det held high for three cycles.
`ifdef SEQ_HIT_EDGE_EN
        tbl.push_back(mk("held1", 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("held2", 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("held3", 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("held_end", 0, 0, 1, 1, 0, 0));
`else
        tbl.push_back(mk("held1", 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("held2", 1, 0, 2, 2, 1, 0));
        tbl.push_back(mk("held3", 1, 0, 3, 2, 1, 0));
        tbl.push_back(mk("held_end", 0, 0, 3, 2, 1, 0));
`endif
        tbl.push_back(mk("clr4", 0, 1, 0, 0, 0, 0));
        run_tbl();

        // Asynchronous reset between edges, mid-window.
        apply(mk("pre_rst", 1, 0, 1, 1, 0, 0));
        #2;
        rst = 1'b0;
        #1;
        check_main(mk("async_rst", 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        bus_m.det = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        apply(mk("post_rst", 1, 0, 1, 1, 0, 0));
        apply(mk("post_rst_gap", 0, 0, 1, 1, 0, 0));

        // Saturation on the narrow instance: 17 pulses, 8 cycles apart.
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            bus_s.det = 1'b1;
            @(negedge clk);
            bus_s.det = 1'b0;
            check($sformatf("sat%0d.total", n), 32'(bus_s.total), (n < 15) ? n : 15);
            check($sformatf("sat%0d.ovf", n), 32'(bus_s.ovf), (n >= 16) ? 1 : 0);
            check($sformatf("sat%0d.alarm", n), 32'(bus_s.alarm), 0);
            check($sformatf("sat%0d.win_cnt", n), 32'(bus_s.win_cnt), 1);
            repeat (6) @(negedge clk);
            check($sformatf("sat%0d.win_closed", n), 32'(bus_s.win_cnt), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
